// File: rtl/goose_pkg.sv
// Shared goose game types: the hit-detect state encoding, screen geometry and the collision
// defaults that the score and obstacle blocks also use.
package goose_pkg;

  typedef enum logic [1:0] {
    GRACE = 2'd0,
    RUN   = 2'd1,
    HIT   = 2'd2
  } goose_state_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int GROUND_Y = 380;

  localparam int HIT_THRESH_DEF   = 4;
  localparam int GRACE_FRAMES_DEF = 60;
  localparam int CNT_W_DEF        = 12;
  localparam int FLASH_FRAMES_DEF = 8;

  // Bits needed to hold 0..max_val. The result is never below 1, so zero-width vectors cannot occur.
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/goose_sat_counter.sv
// Saturating up-counter. clr takes priority over inc and restarts the count at 0, or at 1 when load1 is set.
// Latency is one cycle. There is no backpressure: the counter holds at all-ones.
module goose_sat_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(load1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/goose_hit_detect.sv
// Per-frame goose/obstacle overlap counter. It makes a sticky hit decision one cycle after frame_tick and has no backpressure.
// Optional GOOSE_HIT_FLASH_EN: drives a blink on flash during the grace period, held at 0 in RUN and at 1 in HIT.
module goose_hit_detect
  import goose_pkg::*;
#(
  parameter int HIT_THRESH   = HIT_THRESH_DEF,
  parameter int GRACE_FRAMES = GRACE_FRAMES_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             goose,
  input  logic             obstacle,
  input  logic             frame_tick,
  output logic             check_hit,
  output logic             hit_pulse,
  output logic             grace_active,
  output logic [CNT_W-1:0] ovl_last,
  output logic             flash
);

  localparam int                 GW          = width_for(GRACE_FRAMES);
  localparam logic [GW-1:0]      GRACE_INIT  = GW'(GRACE_FRAMES);
  localparam logic [CNT_W-1:0]   THRESH      = CNT_W'(HIT_THRESH);
  localparam goose_state_e       RESET_STATE = (GRACE_FRAMES == 0) ? RUN : GRACE;

  goose_state_e     state_q, state_d;
  logic [GW-1:0]    grace_q, grace_d;
  logic             pulse_d;
  logic             hit_px;
  logic [CNT_W-1:0] ovl_cnt;

  assign hit_px = pix_en & goose & obstacle;

  // An overlap pixel in the tick cycle belongs to the new frame, so it seeds the count at 1.
  goose_sat_counter #(.W(CNT_W)) u_ovl_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_tick),
    .load1 (hit_px),
    .inc   (hit_px),
    .cnt   (ovl_cnt)
  );

  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    pulse_d = 1'b0;
    case (state_q)
      GRACE: begin
        if (frame_tick) begin
          grace_d = grace_q - GW'(1);
          if (grace_q == GW'(1)) state_d = RUN;
        end
      end
      RUN: begin
        if (frame_tick && (ovl_cnt >= THRESH)) begin
          state_d = HIT;
          pulse_d = 1'b1;
        end
      end
      HIT:     state_d = HIT;
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      grace_q   <= GRACE_INIT;
      hit_pulse <= 1'b0;
      ovl_last  <= '0;
    end else begin
      state_q   <= state_d;
      grace_q   <= grace_d;
      hit_pulse <= pulse_d;
      if (frame_tick) ovl_last <= ovl_cnt;
    end
  end

  assign check_hit    = (state_q == HIT);
  assign grace_active = (state_q == GRACE);

`ifdef GOOSE_HIT_FLASH_EN
  localparam int FW = width_for(FLASH_FRAMES);

  logic [FW-1:0] flash_cnt;
  logic          flash_wrap;
  logic          flash_q;

  // flash_cnt counts frames modulo FLASH_FRAMES from reset, independently of state.
  assign flash_wrap = frame_tick && (flash_cnt == FW'(FLASH_FRAMES - 1));

  goose_sat_counter #(.W(FW)) u_flash_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (flash_wrap),
    .load1 (1'b0),
    .inc   (frame_tick),
    .cnt   (flash_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      flash_q <= 1'b0;
    end else if ((state_q == GRACE) && flash_wrap) begin
      flash_q <= ~flash_q;
    end
  end

  assign flash = (state_q == HIT) | ((state_q == GRACE) & flash_q);
`else
  assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_goose_hit_detect.sv
// Randomised bench for goose_hit_detect, checked against a frame-level reference model.
module tb_goose_hit_detect;

  localparam int HT = 4, GF = 60, CW = 8, FF = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, pix_en = 1'b0, goose = 1'b0, obstacle = 1'b0, frame_tick = 1'b0;
  logic check_hit, hit_pulse, grace_active, flash;
  logic [CW-1:0] ovl_last;

  always #5 clk = ~clk;

  goose_hit_detect #(
    .HIT_THRESH(HT), .GRACE_FRAMES(GF), .CNT_W(CW), .FLASH_FRAMES(FF)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .goose(goose), .obstacle(obstacle),
    .frame_tick(frame_tick), .check_hit(check_hit), .hit_pulse(hit_pulse),
    .grace_active(grace_active), .ovl_last(ovl_last), .flash(flash)
  );

  int n_pass = 0, n_total = 0;

  // Reference model: overlap pixels this frame (unsaturated), ticks since reset, hit flag.
  int m_cnt = 0, m_last = 0, m_ticks = 0;
  bit m_hit = 1'b0, m_pulse = 1'b0, m_flash_t = 1'b0;

  function automatic bit m_grace();
    return !m_hit && (m_ticks < GF);
  endfunction

  function automatic bit m_flash();
`ifdef GOOSE_HIT_FLASH_EN
    return m_hit ? 1'b1 : (m_grace() ? m_flash_t : 1'b0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input bit r, input bit pe, input bit g, input bit o, input bit t);
    bit px;
    int sat;
    reset = r; pix_en = pe; goose = g; obstacle = o; frame_tick = t;
    @(posedge clk);
    px  = pe & g & o;
    sat = (m_cnt > MAXC) ? MAXC : m_cnt;
    m_pulse = 1'b0;
    if (r) begin
      m_cnt = 0; m_last = 0; m_ticks = 0; m_hit = 1'b0; m_flash_t = 1'b0;
    end else if (t) begin
      if (m_grace()) begin
        m_ticks++;
        if (m_ticks % FF == 0) m_flash_t = !m_flash_t;
      end else begin
        m_ticks++;
        if (!m_hit && sat >= HT) begin
          m_hit = 1'b1; m_pulse = 1'b1;
        end
      end
      m_last = sat;
      m_cnt  = px;
    end else begin
      m_cnt += px;
    end
    #1;
  endtask

  task automatic noise_px();
    logic [2:0] v;
    v = 3'($urandom_range(0, 6));
    step(1'b0, v[2], v[1], v[0], 1'b0);
  endtask

  // Overlap and non-counting pixels in random order, then the frame_tick cycle.
  task automatic frame(input int n_ovl, input int n_noise, input bit tick_px);
    int a, b;
    a = n_ovl; b = n_noise;
    while (a + b > 0) begin
      if (a > 0 && (b == 0 || $urandom_range(0, 1) == 1)) begin
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); a--;
      end else begin
        noise_px(); b--;
      end
    end
    step(1'b0, tick_px, tick_px, tick_px, 1'b1);
  endtask

  task automatic run_grace();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (GF) frame($urandom_range(0, 8), $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++; if (check_hit !== 1'b0) $display("FAIL reset_check_hit: got %b want 0", check_hit); else n_pass++;
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL reset_hit_pulse: got %b want 0", hit_pulse); else n_pass++;
    n_total++; if (ovl_last !== 8'd0) $display("FAIL reset_ovl_last: got %0d want 0", ovl_last); else n_pass++;
    n_total++; if (grace_active !== 1'b1) $display("FAIL reset_grace_active: got %b want 1", grace_active); else n_pass++;
    n_total++; if (flash !== 1'b0) $display("FAIL reset_flash: got %b want 0", flash); else n_pass++;
  endtask

  task automatic test_grace();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= GF; i++) begin
      frame(100, $urandom_range(0, 5), 1'b0);
      n_total++; if (check_hit !== 1'b0) $display("FAIL grace_check_hit tick %0d: got %b want 0", i, check_hit); else n_pass++;
      n_total++; if (ovl_last !== 8'd100) $display("FAIL grace_ovl_last tick %0d: got %0d want 100", i, ovl_last); else n_pass++;
      n_total++; if (grace_active !== (i < GF)) $display("FAIL grace_active tick %0d: got %b want %b", i, grace_active, i < GF); else n_pass++;
      n_total++; if (flash !== m_flash()) $display("FAIL grace_flash tick %0d: got %b want %b", i, flash, m_flash()); else n_pass++;
    end
  endtask

  task automatic test_threshold();
    frame(3, $urandom_range(0, 6), 1'b0);
    n_total++; if (check_hit !== 1'b0) $display("FAIL thr3_check_hit: got %b want 0", check_hit); else n_pass++;
    n_total++; if (ovl_last !== 8'd3) $display("FAIL thr3_ovl_last: got %0d want 3", ovl_last); else n_pass++;
    frame(4, $urandom_range(0, 6), 1'b0);
    n_total++; if (check_hit !== 1'b1) $display("FAIL thr4_check_hit: got %b want 1", check_hit); else n_pass++;
    n_total++; if (hit_pulse !== 1'b1) $display("FAIL thr4_hit_pulse: got %b want 1", hit_pulse); else n_pass++;
    n_total++; if (ovl_last !== 8'd4) $display("FAIL thr4_ovl_last: got %0d want 4", ovl_last); else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_total++; if (hit_pulse !== 1'b0) $display("FAIL thr_pulse_drop: got %b want 0", hit_pulse); else n_pass++;
    n_total++; if (check_hit !== 1'b1) $display("FAIL thr_sticky: got %b want 1", check_hit); else n_pass++;
    n_total++; if (flash !== m_flash()) $display("FAIL thr_flash: got %b want %b", flash, m_flash()); else n_pass++;
  endtask

  task automatic test_tick_overlap();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (GF - 2) frame($urandom_range(0, 8), 1, 1'b0);
    frame(4, 2, 1'b1);
    n_total++; if (ovl_last !== 8'd4) $display("FAIL tickpx_grace_last: got %0d want 4", ovl_last); else n_pass++;
    frame(3, 2, 1'b0);
    n_total++; if (ovl_last !== 8'd4) $display("FAIL tickpx_grace_carry: got %0d want 4", ovl_last); else n_pass++;
    n_total++; if (check_hit !== 1'b0) $display("FAIL tickpx_grace_nohit: got %b want 0", check_hit); else n_pass++;
    frame(2, 1, 1'b1);
    n_total++; if (ovl_last !== 8'd2 || check_hit !== 1'b0) $display("FAIL tickpx_run_first: got last=%0d hit=%b want last=2 hit=0", ovl_last, check_hit); else n_pass++;
    frame(3, 1, 1'b0);
    n_total++; if (ovl_last !== 8'd4) $display("FAIL tickpx_run_last: got %0d want 4", ovl_last); else n_pass++;
    n_total++; if (check_hit !== 1'b1 || hit_pulse !== 1'b1) $display("FAIL tickpx_run_hit: got hit=%b pulse=%b want 1 1", check_hit, hit_pulse); else n_pass++;
  endtask

  task automatic test_saturation();
    run_grace();
    frame(300, 5, 1'b0);
    n_total++; if (ovl_last !== 8'd255) $display("FAIL sat_ovl_last: got %0d want 255", ovl_last); else n_pass++;
    n_total++; if (check_hit !== 1'b1 || hit_pulse !== 1'b1) $display("FAIL sat_hit: got hit=%b pulse=%b want 1 1", check_hit, hit_pulse); else n_pass++;
    frame(7, 2, 1'b0);
    n_total++; if (ovl_last !== 8'd7) $display("FAIL hit_ovl_update: got %0d want 7", ovl_last); else n_pass++;
    n_total++; if (check_hit !== 1'b1 || hit_pulse !== 1'b0) $display("FAIL hit_terminal: got hit=%b pulse=%b want 1 0", check_hit, hit_pulse); else n_pass++;
  endtask

  task automatic test_reset_in_hit();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++; if (check_hit !== 1'b0) $display("FAIL rsthit_check_hit: got %b want 0", check_hit); else n_pass++;
    n_total++; if (ovl_last !== 8'd0) $display("FAIL rsthit_ovl_last: got %0d want 0", ovl_last); else n_pass++;
    n_total++; if (grace_active !== 1'b1) $display("FAIL rsthit_grace: got %b want 1", grace_active); else n_pass++;
    n_total++; if (flash !== 1'b0) $display("FAIL rsthit_flash: got %b want 0", flash); else n_pass++;
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_total++; if (ovl_last !== 8'd0) $display("FAIL nocount_ovl_last: got %0d want 0", ovl_last); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 75; f++) begin
        frame($urandom_range(0, HT + 1), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        n_total++;
        if (check_hit !== m_hit || hit_pulse !== m_pulse || ovl_last !== CW'(m_last) ||
            grace_active !== m_grace() || flash !== m_flash())
          $display("FAIL random run %0d frame %0d: got hit=%b pulse=%b last=%0d grace=%b flash=%b want %b %b %0d %b %b",
                   r, f, check_hit, hit_pulse, ovl_last, grace_active, flash,
                   m_hit, m_pulse, m_last, m_grace(), m_flash());
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_grace();
    test_threshold();
    test_tick_overlap();
    test_saturation();
    test_reset_in_hit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
